// File: rtl/wb_stage_p.sv
// Writeback stage: picks one of NSRC result sources or a formatted load word and
// emits a registered one-cycle writeback pulse; loads may wait on a late response.
module wb_stage_p #(
    parameter int DW     = 32,
    parameter int NSRC   = 5,
    parameter int LD_IDX = 2,
    parameter int TMO    = 15,
    parameter int SELW   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NSRC*DW-1:0]   i_src_data,
    input  logic [SELW-1:0]      i_wb_sel,
    input  logic [4:0]           i_rd_addr,
    input  logic                 i_rd_wren,
    input  logic [1:0]           i_ld_size,
    input  logic                 i_ld_unsigned,
    input  logic [1:0]           i_ld_offset,
    input  logic                 i_ld_valid,
    input  logic [DW-1:0]        i_ld_data,
    output logic                 o_wb_valid,
    output logic [DW-1:0]        o_wb_data,
    output logic [4:0]           o_rd_addr,
    output logic                 o_rd_wren,
    output logic                 o_ld_err,
    output logic                 o_dbg_state
);

    localparam int CW = $clog2(TMO + 1);

    typedef enum logic {IDLE = 1'b0, WAIT_LD = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [4:0]      cap_rd;
    logic            cap_wren;
    logic [1:0]      cap_size;
    logic            cap_uns;
    logic [1:0]      cap_off;

    logic            accept, is_ld, ld_misal, ld_to;
    logic [DW-1:0]   src_val;
    logic            fire, err, wren_nxt;
    logic [DW-1:0]   data_nxt;
    logic [4:0]      addr_nxt;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
    endfunction

    // Lane is zero-extended into 32 bits first; sign bits above the lane are OR-ed in.
    function automatic logic [DW-1:0] fmt_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
        logic [31:0]   lane;
        logic [DW-1:0] keep;
        logic          sign;
        keep = '0;
        case (size)
            2'b00: begin
                lane = {24'h0, w[{off, 3'b000} +: 8]};
                keep[7:0] = '1;
                sign = lane[7];
            end
            2'b01: begin
                lane = {16'h0, w[{off[1], 4'b0000} +: 16]};
                keep[15:0] = '1;
                sign = lane[15];
            end
            default: begin
                lane = w;
                keep[31:0] = '1;
                sign = w[31];
            end
        endcase
        return DW'(lane) | ((sign && !uns) ? ~keep : '0);
    endfunction

    // Handshake: an instruction transfers on a rising edge where i_valid and o_ready
    // are both 1; o_ready is high only in IDLE outside reset and never depends on i_valid.
    assign accept   = i_valid && (state == IDLE) && !i_reset;
    assign is_ld    = (i_wb_sel == SELW'(LD_IDX));
    assign ld_misal = misaligned(i_ld_size, i_ld_offset);
    assign ld_to    = (cnt == CW'(TMO));

    always_comb begin
        src_val = '0;
        for (int n = 0; n < NSRC; n++)
            if (i_wb_sel == SELW'(n)) src_val = i_src_data[n*DW +: DW];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_rd   <= '0;
            cap_wren <= 1'b0;
            cap_size <= '0;
            cap_uns  <= 1'b0;
            cap_off  <= '0;
        end else begin
            state <= state_nxt;
            if (accept && is_ld) begin
                cap_rd   <= i_rd_addr;
                cap_wren <= i_rd_wren;
                cap_size <= i_ld_size;
                cap_uns  <= i_ld_unsigned;
                cap_off  <= i_ld_offset;
                cnt      <= '0;
            end else if (state == WAIT_LD && !i_ld_valid && !ld_to) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_ld && !ld_misal && !i_ld_valid) state_nxt = WAIT_LD;
            WAIT_LD: if (i_ld_valid || ld_to) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (state == IDLE) && !i_reset;
        o_dbg_state = state;
        fire        = 1'b0;
        err         = 1'b0;
        data_nxt    = '0;
        addr_nxt    = i_rd_addr;
        wren_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_ld) begin
                        fire     = 1'b1;
                        data_nxt = src_val;
                        wren_nxt = i_rd_wren && (i_rd_addr != 5'd0);
                    end else if (ld_misal) begin
                        fire = 1'b1;
                        err  = 1'b1;
                    end else if (i_ld_valid) begin
                        fire     = 1'b1;
                        data_nxt = fmt_load(i_ld_data[31:0], i_ld_size, i_ld_unsigned, i_ld_offset);
                        wren_nxt = i_rd_wren && (i_rd_addr != 5'd0);
                    end
                end
            end
            WAIT_LD: begin
                addr_nxt = cap_rd;
                if (i_ld_valid) begin
                    fire     = 1'b1;
                    data_nxt = fmt_load(i_ld_data[31:0], cap_size, cap_uns, cap_off);
                    wren_nxt = cap_wren && (cap_rd != 5'd0);
                end else if (ld_to) begin
                    fire = 1'b1;
                    err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Data/address/enable only move on a writeback so they hold between pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_valid <= 1'b0;
            o_ld_err   <= 1'b0;
            o_wb_data  <= '0;
            o_rd_addr  <= '0;
            o_rd_wren  <= 1'b0;
        end else begin
            o_wb_valid <= fire;
            o_ld_err   <= err;
            if (fire) begin
                o_wb_data <= data_nxt;
                o_rd_addr <= addr_nxt;
                o_rd_wren <= wren_nxt;
            end
        end
    end

endmodule
